// File: rtl/change_pkg.sv
// ============================================================================
// Module  : change_pkg
// Brief   : Shared FSM states, coin values and coin-select encoding for the
//           change dispenser.
// Revision: 1.0
// ============================================================================
`default_nettype none

package change_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_SELECT = 3'd1;
  localparam state_t S_PULSE  = 3'd2;
  localparam state_t S_GAP    = 3'd3;
  localparam state_t S_DONE   = 3'd4;

  localparam int unsigned QUARTER_C = 25;
  localparam int unsigned DIME_C    = 10;
  localparam int unsigned NICKEL_C  = 5;

  // One-hot coin select, bit order matches {quarter, dime, nickel}
  typedef logic [2:0] coin_t;

  localparam coin_t COIN_NONE = 3'b000;
  localparam coin_t COIN_Q    = 3'b100;
  localparam coin_t COIN_D    = 3'b010;
  localparam coin_t COIN_N    = 3'b001;

  function automatic int unsigned coin_value(input coin_t c);
    case (c)
      COIN_Q:  return QUARTER_C;
      COIN_D:  return DIME_C;
      COIN_N:  return NICKEL_C;
      default: return 0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/coin_pulse_timer.sv
// ============================================================================
// Module  : coin_pulse_timer
// Brief   : Loadable down-counter; expire_o is high on the last cycle of the
//           loaded interval (load value = cycles - 1).
// Revision: 1.0
// ============================================================================
`default_nettype none

module coin_pulse_timer #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             expire_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign expire_o = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/change_dispenser.sv
// ============================================================================
// Module  : change_dispenser
// Brief   : Greedy quarter/dime/nickel payout as timed ejector pulses.
//           Optional per-coin stock tracking under CHANGE_INVENTORY_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module change_dispenser
  import change_pkg::*;
#(
  parameter int AMT_W        = 7,
  parameter int PULSE_CYCLES = 4,
  parameter int GAP_CYCLES   = 2
`ifdef CHANGE_INVENTORY_EN
  ,
  parameter int STOCK_W      = 6
`endif
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [AMT_W-1:0] change_in,
`ifdef CHANGE_INVENTORY_EN
  input  logic             refill,
  output logic [2:0]       empty,
`endif
  output logic             quarter_out,
  output logic             dime_out,
  output logic             nickel_out,
  output logic             busy,
  output logic             done,
  output logic             short
);

  localparam int MAX_CYC = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  state_t           state_q, state_d;
  logic [AMT_W-1:0] rem_q, rem_d;
  coin_t            coin_q, coin_d;
  logic             short_q, short_d;
  logic             quarter_q, dime_q, nickel_q, busy_q, done_q;

  logic             timer_load;
  logic [CNT_W-1:0] timer_val;
  logic             timer_expire;

  logic             q_avail, d_avail, n_avail;
  coin_t            pick;
  logic             take;

  always_comb begin
    pick = COIN_NONE;
    if (rem_q >= AMT_W'(QUARTER_C) && q_avail) begin
      pick = COIN_Q;
    end else if (rem_q >= AMT_W'(DIME_C) && d_avail) begin
      pick = COIN_D;
    end else if (rem_q >= AMT_W'(NICKEL_C) && n_avail) begin
      pick = COIN_N;
    end
  end

  assign take = (state_q == S_SELECT) && (pick != COIN_NONE);

`ifdef CHANGE_INVENTORY_EN
  logic [STOCK_W-1:0] q_stock_q, d_stock_q, n_stock_q;

  // Stock is consumed on the SELECT->PULSE transition; refill overrides it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_stock_q <= '1;
      d_stock_q <= '1;
      n_stock_q <= '1;
    end else if (refill) begin
      q_stock_q <= '1;
      d_stock_q <= '1;
      n_stock_q <= '1;
    end else if (take) begin
      if (pick == COIN_Q) q_stock_q <= q_stock_q - STOCK_W'(1);
      if (pick == COIN_D) d_stock_q <= d_stock_q - STOCK_W'(1);
      if (pick == COIN_N) n_stock_q <= n_stock_q - STOCK_W'(1);
    end
  end

  assign q_avail = (q_stock_q != '0);
  assign d_avail = (d_stock_q != '0);
  assign n_avail = (n_stock_q != '0);
  assign empty   = {~q_avail, ~d_avail, ~n_avail};
`else
  assign q_avail = 1'b1;
  assign d_avail = 1'b1;
  assign n_avail = 1'b1;
`endif

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    coin_d     = coin_q;
    short_d    = short_q;
    timer_load = 1'b0;
    timer_val  = '0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          rem_d   = change_in;
          short_d = 1'b0;
          state_d = S_SELECT;
        end
      end
      S_SELECT: begin
        coin_d = pick;
        if (take) begin
          rem_d      = rem_q - AMT_W'(coin_value(pick));
          state_d    = S_PULSE;
          timer_load = 1'b1;
          timer_val  = CNT_W'(PULSE_CYCLES - 1);
        end else begin
          state_d = S_DONE;
          short_d = (rem_q != '0);
        end
      end
      S_PULSE: begin
        if (timer_expire) begin
          state_d    = S_GAP;
          timer_load = 1'b1;
          timer_val  = CNT_W'(GAP_CYCLES - 1);
        end
      end
      S_GAP: begin
        if (timer_expire) state_d = S_SELECT;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  coin_pulse_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_i     (timer_load),
    .load_val_i (timer_val),
    .expire_o   (timer_expire)
  );

  // Outputs are registered from next-state so they align with the state they describe
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      rem_q     <= '0;
      coin_q    <= COIN_NONE;
      short_q   <= 1'b0;
      quarter_q <= 1'b0;
      dime_q    <= 1'b0;
      nickel_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      coin_q    <= coin_d;
      short_q   <= short_d;
      quarter_q <= (state_d == S_PULSE) && (coin_d == COIN_Q);
      dime_q    <= (state_d == S_PULSE) && (coin_d == COIN_D);
      nickel_q  <= (state_d == S_PULSE) && (coin_d == COIN_N);
      busy_q    <= (state_d != S_IDLE);
      done_q    <= (state_d == S_DONE);
    end
  end

  assign quarter_out = quarter_q;
  assign dime_out    = dime_q;
  assign nickel_out  = nickel_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign short       = short_q;

endmodule

`default_nettype wire

// File: tb/tb_change_dispenser.sv
// ============================================================================
// Module  : tb_change_dispenser
// Brief   : Self-checking bench for change_dispenser (PULSE_CYCLES=2,
//           GAP_CYCLES=1); honours CHANGE_INVENTORY_EN when defined.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_change_dispenser;

  localparam int AMT_W  = 7;
  localparam int PC     = 2;
  localparam int GC     = 1;
  localparam int PERIOD = PC + GC + 1;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             start = 1'b0;
  logic [AMT_W-1:0] change_in = '0;
  logic             quarter_out, dime_out, nickel_out, busy, done, short;

`ifdef CHANGE_INVENTORY_EN
  localparam int STOCK_W = 2;
  logic       refill = 1'b0;
  logic [2:0] empty;
`endif

  int stock [3];
  int vectors = 0;
  int miscompares = 0;

  change_dispenser #(
    .AMT_W        (AMT_W),
    .PULSE_CYCLES (PC),
    .GAP_CYCLES   (GC)
`ifdef CHANGE_INVENTORY_EN
    ,
    .STOCK_W      (STOCK_W)
`endif
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .change_in   (change_in),
`ifdef CHANGE_INVENTORY_EN
    .refill      (refill),
    .empty       (empty),
`endif
    .quarter_out (quarter_out),
    .dime_out    (dime_out),
    .nickel_out  (nickel_out),
    .busy        (busy),
    .done        (done),
    .short       (short)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit has_stock(input int t);
`ifdef CHANGE_INVENTORY_EN
    return stock[t] > 0;
`else
    return (t >= 0);
`endif
  endfunction

  task automatic stock_full();
    for (int t = 0; t < 3; t++) stock[t] = 1 << 6;
`ifdef CHANGE_INVENTORY_EN
    for (int t = 0; t < 3; t++) stock[t] = (1 << STOCK_W) - 1;
`endif
  endtask

`ifdef CHANGE_INVENTORY_EN
  task automatic do_refill();
    @(negedge clk);
    refill = 1'b1;
    @(negedge clk);
    refill = 1'b0;
    stock_full();
    chk("empty_after_refill", {29'd0, empty}, 32'd0);
  endtask
`endif

  // Reference: greedy payout list, then a cycle-by-cycle timeline derived from it
  task automatic run(input int amt, input bit noise);
    int  cval [3];
    int  coins [$];
    int  rem, n, dc, k, ph;
    bit  go, exp_short;
    logic eq, ed, en;
    cval[0] = 25; cval[1] = 10; cval[2] = 5;
    rem = amt;
    go  = 1'b1;
    while (go) begin
      int pick;
      pick = -1;
      for (int t = 0; t < 3; t++)
        if (pick < 0 && rem >= cval[t] && has_stock(t)) pick = t;
      if (pick < 0) begin
        go = 1'b0;
      end else begin
        coins.push_back(pick);
        rem -= cval[pick];
`ifdef CHANGE_INVENTORY_EN
        stock[pick]--;
`endif
      end
    end
    n         = coins.size();
    exp_short = (rem != 0);
    dc        = 2 + n * PERIOD;

    @(negedge clk);
    start     = 1'b1;
    change_in = AMT_W'(amt);
    for (int c = 1; c <= dc + 1; c++) begin
      @(negedge clk);
      start = (noise && c <= dc) ? 1'b1 : 1'b0;
      if (noise) change_in = AMT_W'($urandom_range(0, 127));
      eq = 1'b0; ed = 1'b0; en = 1'b0;
      if (c >= 2) begin
        k  = (c - 2) / PERIOD;
        ph = (c - 2) % PERIOD;
        if (k < n && ph < PC) begin
          eq = (coins[k] == 0);
          ed = (coins[k] == 1);
          en = (coins[k] == 2);
        end
      end
      chk("quarter_out", 32'(quarter_out), 32'(eq));
      chk("dime_out",    32'(dime_out),    32'(ed));
      chk("nickel_out",  32'(nickel_out),  32'(en));
      chk("busy",        32'(busy),        32'(c <= dc));
      chk("done",        32'(done),        32'(c == dc));
      chk("short",       32'(short),       32'((c >= dc) ? exp_short : 1'b0));
    end
`ifdef CHANGE_INVENTORY_EN
    chk("empty", {29'd0, empty},
        {29'd0, stock[0] == 0, stock[1] == 0, stock[2] == 0});
`endif
  endtask

  task automatic reset_mid();
    @(negedge clk);
    start     = 1'b1;
    change_in = AMT_W'(55);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("rst_pre_quarter", 32'(quarter_out), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_async_quarter", 32'(quarter_out), 32'd0);
    chk("rst_async_busy",    32'(busy),        32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    stock_full();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("post_rst_busy", 32'(busy), 32'd0);
      chk("post_rst_done", 32'(done), 32'd0);
      chk("post_rst_coin", {29'd0, quarter_out, dime_out, nickel_out}, 32'd0);
    end
  endtask

  initial begin
    stock_full();
    repeat (2) @(negedge clk);
    chk("reset_coins", {29'd0, quarter_out, dime_out, nickel_out}, 32'd0);
    chk("reset_busy",  32'(busy),  32'd0);
    chk("reset_done",  32'(done),  32'd0);
    chk("reset_short", 32'(short), 32'd0);
`ifdef CHANGE_INVENTORY_EN
    chk("reset_empty", {29'd0, empty}, 32'd0);
`endif
    reset_n = 1'b1;

    run(30, 1'b0);
    run(45, 1'b0);
    run(0,  1'b0);
    run(7,  1'b0);
    run(5,  1'b0);
    run(55, 1'b1);
    reset_mid();
    for (int i = 0; i < 12; i++) begin
`ifdef CHANGE_INVENTORY_EN
      if (i % 3 == 0) do_refill();
`endif
      run(int'($urandom_range(0, 127)), bit'($urandom_range(0, 1)));
    end
`ifdef CHANGE_INVENTORY_EN
    do_refill();
    run(75, 1'b0);
    run(25, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
